ysyx_22051013_hzd_det: RTL and testbench
========================================

# ysyx_22051013_hzd_det

ID-stage hazard detector and long-latency scoreboard for the pipelined core. Tracks destination registers of in-flight loads and mul/div ops from issue until writeback, and raises `id_stall_ena` toward the hazard controller whenever the ID instruction has a RAW or WAW dependence on a pending result, or when the outstanding-op budget is exhausted. It is the producer of the stall request that the hazard controller turns into IF/ID stall and ID/EX bubble.

## Interface
- `MAX_OUT`, 4: maximum simultaneously outstanding long-latency ops (1..15).
- `STALL_MAX`, 255: consecutive-stall watchdog limit (used only with the watchdog macro).
- `clk  input  1  core clock; all state updates on rising edge`
- `rst  input  1  reset, asynchronous, active-low`
- `id_valid  input  1  ID holds a valid instruction`
- `id_rs1 / id_rs2  input  5  source register indices`
- `id_rs1_ren / id_rs2_ren  input  1  source actually read`
- `id_rd  input  5  destination index`
- `id_rd_wen  input  1  instruction writes rd`
- `id_long  input  1  instruction is a load or mul/div (result at WB, no forwarding)`
- `ex_jump_ena  input  1  EX redirect; kills the ID instruction this cycle`
- `wb_wen  input  1  writeback commits this cycle`
- `wb_rd  input  5  writeback destination`
- `wb_long  input  1  committing op is a long-latency op`
- `id_stall_ena  output  1  stall request to hazard controller`
- `busy_vec  output  32  scoreboard busy bits, bit 0 constant 0`
- `out_cnt  output  4  outstanding long-latency op count`
- `hzd_err  output  1  sticky watchdog error`

## Operation
- RAW1 = `id_rs1_ren & id_rs1!=0 & busy_vec[id_rs1]`; RAW2 likewise for rs2.
- WAW = `id_rd_wen & id_rd!=0 & busy_vec[id_rd]`.
- FULL = `id_long & out_cnt==MAX_OUT`.
- `id_stall_ena = id_valid & ~ex_jump_ena & (RAW1|RAW2|WAW|FULL)`; purely combinational from registered state and current ID inputs.
- Issue = `id_valid & ~ex_jump_ena & ~id_stall_ena`. Killed (ex_jump_ena) or stalled instructions update nothing.
- On issue with `id_long & id_rd_wen & id_rd!=0`: set `busy_vec[id_rd]`.
- On issue with `id_long`: increment `out_cnt` (a long op with rd=x0 or no write still counts).
- On `wb_wen & wb_long & wb_rd!=0`: clear `busy_vec[wb_rd]`.
- On `wb_long` with `wb_wen` or for rd=x0 commit: decrement `out_cnt`; caller asserts `wb_long` exactly once per issued long op.
- Same-cycle issue and writeback: increment and decrement cancel (count unchanged). Set and clear of the same register cannot coincide because WAW stalls the issue; the clear wins if it ever does.
- No WB-to-ID bypass: a register cleared at cycle N is usable in ID at cycle N+1.
- x0 is never busy; `busy_vec[0]` tied 0.
- `out_cnt` never exceeds `MAX_OUT`; decrement at 0 is ignored (saturate), increment at `MAX_OUT` cannot occur (FULL stall).

## Timing
- Reset (rst low, asynchronous): `busy_vec`=0, `out_cnt`=0, `hzd_err`=0, watchdog counter 0; `id_stall_ena` therefore 0 during reset.
- Reset mid-operation discards all pending tracking; in-flight ops are assumed flushed by the same reset.
- Stall response: zero latency (same cycle as ID inputs).
- Scoreboard/count update: visible the cycle after issue or writeback.
- Minimum load-use penalty: stall holds from ID cycle until the cycle after the matching `wb_wen`.

## Configuration
- `YSYX_22051013_HZD_WDOG_EN` defined: a counter increments each cycle `id_stall_ena` is 1, resets to 0 on any cycle it is 0; on reaching `STALL_MAX` it sets `hzd_err`, which stays 1 until reset. Counter saturates.
- Not defined: no counter logic; `hzd_err` tied 0; port still present.

## Test plan
- Load to x5 issues, next instr reads rs1=x5 -> `id_stall_ena`=1 until cycle after `wb_wen,wb_rd=5,wb_long`; `busy_vec[5]` 1 then 0; `out_cnt` 1 then 0.
- Long op with rd=x0, then reader of x0 -> no stall; `busy_vec`=0; `out_cnt`=1 until its wb_long.
- MAX_OUT=4 long ops to x1..x4 back-to-back, 5th long op to x6 -> stall on 5th; one wb_long retire -> 5th issues next cycle, `out_cnt` stays 4.
- Long op to x7 pending, ID long op writes x7 -> WAW stall; same cycle `ex_jump_ena`=1 -> `id_stall_ena`=0 and no state change.
- Issue long op and retire another long op in the same cycle -> `out_cnt` unchanged; rst pulled low mid-stall -> all outputs 0 immediately, asynchronously.
- With `YSYX_22051013_HZD_WDOG_EN`, STALL_MAX=8, hold x9 busy with no writeback while reading x9 -> `hzd_err`=1 after 8 stall cycles, stays 1 after stall drops, cleared only by reset.

Source files
------------

// File: rtl/ysyx_22051013_hzd_det.sv
// ID-stage hazard detector: scoreboard of pending long-latency results, raises RAW/WAW/budget stall.
// Latency: stall request is combinational (0 cycles); busy bits and count update on the next edge.
// Backpressure: stalled or killed ID instructions update nothing; the instruction is held until the stall drops.
//
// Ports:
//   clk, rst (async, active-low)
//   id_valid, id_rs1/id_rs1_ren, id_rs2/id_rs2_ren, id_rd/id_rd_wen, id_long : ID instruction
//   ex_jump_ena                                                        : EX redirect, kills ID instruction
//   wb_wen, wb_rd, wb_long                                             : writeback commit
//   id_stall_ena                                                       : stall request to hazard controller
//   busy_vec, out_cnt, hzd_err                                         : scoreboard state / watchdog error
// Optional: define YSYX_22051013_HZD_WDOG_EN to enable the consecutive-stall watchdog driving hzd_err.
module ysyx_22051013_hzd_det #(
    parameter int MAX_OUT   = 4,
    parameter int STALL_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic        id_rs1_ren,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs2_ren,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_wen,
    input  logic        id_long,
    input  logic        ex_jump_ena,
    input  logic        wb_wen,
    input  logic [4:0]  wb_rd,
    input  logic        wb_long,
    output logic        id_stall_ena,
    output logic [31:0] busy_vec,
    output logic [3:0]  out_cnt,
    output logic        hzd_err
);

    logic [31:1] busy_q;
    logic [3:0]  cnt_q;

    logic        raw1, raw2, waw, full;
    logic        issue, inc, dec;
    logic [31:0] set_mask, clr_mask, busy_nxt;

    // x0 never tracked, so bit 0 is hard-wired low.
    assign busy_vec = {busy_q, 1'b0};
    assign out_cnt  = cnt_q;

    always_comb begin
        raw1         = id_rs1_ren & (id_rs1 != 5'd0) & busy_vec[id_rs1];
        raw2         = id_rs2_ren & (id_rs2 != 5'd0) & busy_vec[id_rs2];
        waw          = id_rd_wen  & (id_rd  != 5'd0) & busy_vec[id_rd];
        full         = id_long & (cnt_q == 4'(MAX_OUT));
        id_stall_ena = id_valid & ~ex_jump_ena & (raw1 | raw2 | waw | full);
        issue        = id_valid & ~ex_jump_ena & ~id_stall_ena;
        inc          = issue & id_long;
        // Count retirements regardless of rd; ignore a stray retire at zero.
        dec          = wb_long & (cnt_q != 4'd0);

        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (issue & id_long & id_rd_wen & (id_rd != 5'd0))
            set_mask[id_rd] = 1'b1;
        if (wb_wen & wb_long & (wb_rd != 5'd0))
            clr_mask[wb_rd] = 1'b1;
        // Clear applied after set so a coincident clear wins.
        busy_nxt = (busy_vec | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= 4'd0;
        end else begin
            busy_q <= busy_nxt[31:1];
            if (inc & ~dec)
                cnt_q <= cnt_q + 4'd1;
            else if (dec & ~inc)
                cnt_q <= cnt_q - 4'd1;
        end
    end

`ifdef YSYX_22051013_HZD_WDOG_EN
    localparam int WD_W = $clog2(STALL_MAX + 1);

    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_nxt;
    logic            err_q;

    always_comb begin
        wd_nxt = '0;
        if (id_stall_ena)
            wd_nxt = (wd_cnt == WD_W'(STALL_MAX)) ? wd_cnt : wd_cnt + WD_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= wd_nxt;
            // Sticky until reset.
            if (wd_nxt == WD_W'(STALL_MAX))
                err_q <= 1'b1;
        end
    end

    assign hzd_err = err_q;
`else
    assign hzd_err = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22051013_hzd_det.sv
module tb_ysyx_22051013_hzd_det;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = 5'd0;
    logic        id_rs1_ren = 1'b0;
    logic [4:0]  id_rs2 = 5'd0;
    logic        id_rs2_ren = 1'b0;
    logic [4:0]  id_rd = 5'd0;
    logic        id_rd_wen = 1'b0;
    logic        id_long = 1'b0;
    logic        ex_jump_ena = 1'b0;
    logic        wb_wen = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic        wb_long = 1'b0;
    logic        id_stall_ena;
    logic [31:0] busy_vec;
    logic [3:0]  out_cnt;
    logic        hzd_err;

`ifdef YSYX_22051013_HZD_WDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    ysyx_22051013_hzd_det #(.MAX_OUT(4), .STALL_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_ren(id_rs1_ren),
        .id_rs2(id_rs2), .id_rs2_ren(id_rs2_ren),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen),
        .id_long(id_long), .ex_jump_ena(ex_jump_ena),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_long(wb_long),
        .id_stall_ena(id_stall_ena), .busy_vec(busy_vec),
        .out_cnt(out_cnt), .hzd_err(hzd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        stall;
        logic [31:0] busy;
        logic [3:0]  cnt;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] b(input int n);
        return 32'd1 << n;
    endfunction

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic r1en,
                          input logic [4:0] rs2, input logic r2en,
                          input logic [4:0] rd, input logic rdwen,
                          input logic lng, input logic jmp);
        id_valid = v; id_rs1 = rs1; id_rs1_ren = r1en; id_rs2 = rs2; id_rs2_ren = r2en;
        id_rd = rd; id_rd_wen = rdwen; id_long = lng; ex_jump_ena = jmp;
    endtask

    task automatic set_wb(input logic wen, input logic [4:0] rd, input logic lng);
        wb_wen = wen; wb_rd = rd; wb_long = lng;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        set_wb(1'b0, 5'd0, 1'b0);
    endtask

    // Long op writing rd, no sources.
    task automatic ld(input logic [4:0] rd);
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0);
    endtask

    // Short op reading rs1 only.
    task automatic rd1(input logic [4:0] rs);
        set_id(1'b1, rs, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input string tag, input logic stall, input logic [31:0] busy,
                        input logic [3:0] cnt, input logic err);
        exp_t e;
        e.tag = tag; e.stall = stall; e.busy = busy; e.cnt = cnt; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        assert (id_stall_ena === e.stall) else begin
            errors++;
            $error("FAIL %s stall got=%0b want=%0b", e.tag, id_stall_ena, e.stall);
        end
        checks++;
        assert (busy_vec === e.busy) else begin
            errors++;
            $error("FAIL %s busy_vec got=%h want=%h", e.tag, busy_vec, e.busy);
        end
        checks++;
        assert (out_cnt === e.cnt) else begin
            errors++;
            $error("FAIL %s out_cnt got=%0d want=%0d", e.tag, out_cnt, e.cnt);
        end
        checks++;
        assert (hzd_err === e.err) else begin
            errors++;
            $error("FAIL %s hzd_err got=%0b want=%0b", e.tag, hzd_err, e.err);
        end
    endtask

    // Inputs are already driven for this cycle; check at #1, well before the next rising edge.
    task automatic chk(input string tag, input logic stall, input logic [31:0] busy,
                       input logic [3:0] cnt, input logic err);
        push(tag, stall, busy, cnt, err);
        #1;
        compare();
    endtask

    initial begin
        // Reset state, with a reader of x5 presented during reset.
        @(negedge clk); rd1(5'd5); set_wb(1'b0, 5'd0, 1'b0);
        chk("reset", 1'b0, 32'd0, 4'd0, 1'b0);
        @(negedge clk); rst = 1'b1; idle(); set_wb(1'b1, 5'd0, 1'b1);
        chk("wb_at_zero", 1'b0, 32'd0, 4'd0, 1'b0);
        @(negedge clk); idle();
        chk("cnt_sat0", 1'b0, 32'd0, 4'd0, 1'b0);

        // Load-use on x5.
        @(negedge clk); ld(5'd5);
        chk("lu_issue", 1'b0, 32'd0, 4'd0, 1'b0);
        @(negedge clk); rd1(5'd5);
        chk("lu_stall1", 1'b1, b(5), 4'd1, 1'b0);
        @(negedge clk); rd1(5'd5);
        chk("lu_stall2", 1'b1, b(5), 4'd1, 1'b0);
        @(negedge clk); rd1(5'd5); set_wb(1'b1, 5'd5, 1'b1);
        chk("lu_wb_cycle", 1'b1, b(5), 4'd1, 1'b0);
        @(negedge clk); rd1(5'd5); set_wb(1'b0, 5'd0, 1'b0);
        chk("lu_release", 1'b0, 32'd0, 4'd0, 1'b0);

        // Long op to x0, then reader/writer of x0.
        @(negedge clk); ld(5'd0);
        chk("x0_issue", 1'b0, 32'd0, 4'd0, 1'b0);
        @(negedge clk); set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("x0_read", 1'b0, 32'd0, 4'd1, 1'b0);
        @(negedge clk); idle(); set_wb(1'b1, 5'd0, 1'b1);
        chk("x0_pending", 1'b0, 32'd0, 4'd1, 1'b0);
        @(negedge clk); idle();
        chk("x0_retired", 1'b0, 32'd0, 4'd0, 1'b0);

        // Outstanding budget.
        @(negedge clk); ld(5'd1);
        chk("full_x1", 1'b0, 32'd0, 4'd0, 1'b0);
        @(negedge clk); ld(5'd2);
        chk("full_x2", 1'b0, b(1), 4'd1, 1'b0);
        @(negedge clk); ld(5'd3);
        chk("full_x3", 1'b0, b(1) | b(2), 4'd2, 1'b0);
        @(negedge clk); ld(5'd4);
        chk("full_x4", 1'b0, b(1) | b(2) | b(3), 4'd3, 1'b0);
        @(negedge clk); ld(5'd6);
        chk("full_stall", 1'b1, b(1) | b(2) | b(3) | b(4), 4'd4, 1'b0);
        @(negedge clk); ld(5'd6); set_wb(1'b1, 5'd1, 1'b1);
        chk("full_retire", 1'b1, b(1) | b(2) | b(3) | b(4), 4'd4, 1'b0);
        @(negedge clk); ld(5'd6); set_wb(1'b0, 5'd0, 1'b0);
        chk("full_issue5", 1'b0, b(2) | b(3) | b(4), 4'd3, 1'b0);
        @(negedge clk); idle(); set_wb(1'b1, 5'd2, 1'b1);
        chk("full_stays4", 1'b0, b(2) | b(3) | b(4) | b(6), 4'd4, 1'b0);
        @(negedge clk); set_wb(1'b1, 5'd3, 1'b1);
        chk("drain1", 1'b0, b(3) | b(4) | b(6), 4'd3, 1'b0);
        @(negedge clk); set_wb(1'b1, 5'd4, 1'b1);
        chk("drain2", 1'b0, b(4) | b(6), 4'd2, 1'b0);
        @(negedge clk); set_wb(1'b1, 5'd6, 1'b1);
        chk("drain3", 1'b0, b(6), 4'd1, 1'b0);
        @(negedge clk); idle();
        chk("drain_done", 1'b0, 32'd0, 4'd0, 1'b0);

        // WAW on x7, and kill by redirect.
        @(negedge clk); ld(5'd7);
        chk("waw_issue", 1'b0, 32'd0, 4'd0, 1'b0);
        @(negedge clk); set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
        chk("waw_killed", 1'b0, b(7), 4'd1, 1'b0);
        @(negedge clk); ld(5'd7);
        chk("waw_stall", 1'b1, b(7), 4'd1, 1'b0);

        // Same-cycle issue (x8) and retire (x7).
        @(negedge clk); ld(5'd8); set_wb(1'b1, 5'd7, 1'b1);
        chk("swap_cycle", 1'b0, b(7), 4'd1, 1'b0);
        @(negedge clk); idle();
        chk("swap_result", 1'b0, b(8), 4'd1, 1'b0);

        // Asynchronous reset in the middle of a stall.
        @(negedge clk); rd1(5'd8);
        chk("pre_arst", 1'b1, b(8), 4'd1, 1'b0);
        #1 rst = 1'b0;
        #1;
        push("arst_async", 1'b0, 32'd0, 4'd0, 1'b0);
        compare();
        @(negedge clk); rst = 1'b1; rd1(5'd8);
        chk("post_arst", 1'b0, 32'd0, 4'd0, 1'b0);

        // Watchdog: hold x9 busy and keep reading it.
        @(negedge clk); ld(5'd9);
        chk("wd_issue", 1'b0, 32'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); rd1(5'd9);
            chk($sformatf("wd_stall%0d", k), 1'b1, b(9), 4'd1, WD & (k > 8));
        end
        @(negedge clk); idle();
        chk("wd_sticky", 1'b0, b(9), 4'd1, WD);
        @(negedge clk); idle(); set_wb(1'b1, 5'd9, 1'b1);
        chk("wd_wb", 1'b0, b(9), 4'd1, WD);
        @(negedge clk); idle();
        chk("wd_still", 1'b0, 32'd0, 4'd0, WD);
        #1 rst = 1'b0;
        #1;
        push("wd_reset", 1'b0, 32'd0, 4'd0, 1'b0);
        compare();
        @(negedge clk); rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
